// File: rtl/rob_commit.sv
// Reorder buffer with in-order commit, commit-RAT/free-list writes,
// exception and interrupt flush. Ports: alloc_*, cmpl_*, commit_*, free_*, flush*.
module rob_commit #(
  parameter int ROB_ENTRIES = 16,
  parameter int NUM_PREGS   = 64,
  parameter int NUM_AREGS   = 32
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           alloc_valid,
  output logic                           alloc_ready,
  input  logic [$clog2(NUM_AREGS)-1:0]   alloc_areg,
  input  logic [$clog2(NUM_PREGS)-1:0]   alloc_preg,
  input  logic [$clog2(NUM_PREGS)-1:0]   alloc_old_preg,
  input  logic                           alloc_mbegin,
  input  logic                           alloc_mend,
  output logic [$clog2(ROB_ENTRIES)-1:0] alloc_idx,
  input  logic                           cmpl_valid,
  input  logic [$clog2(ROB_ENTRIES)-1:0] cmpl_idx,
  input  logic                           cmpl_exc,
  output logic                           commit_valid,
  output logic [$clog2(NUM_AREGS)-1:0]   commit_areg,
  output logic [$clog2(NUM_PREGS)-1:0]   commit_preg,
  output logic                           free_valid,
  output logic [$clog2(NUM_PREGS)-1:0]   free_preg,
  input  logic                           irq_pending,
  output logic                           flush,
  output logic                           flush_cause,
  output logic [$clog2(ROB_ENTRIES):0]   count
);

  localparam int IW = $clog2(ROB_ENTRIES);
  localparam int PW = $clog2(NUM_PREGS);
  localparam int AW = $clog2(NUM_AREGS);
  localparam int CW = IW + 1;

  localparam logic [IW-1:0] I_ONE = IW'(1);
  localparam logic [CW-1:0] C_ONE = CW'(1);
  localparam logic [CW-1:0] C_MAX = CW'(ROB_ENTRIES);

  typedef struct packed {
    logic          valid;
    logic          busy;
    logic          exc;
    logic [AW-1:0] areg;
    logic [PW-1:0] preg;
    logic [PW-1:0] old_preg;
    logic          mbegin;
    logic          mend;
  } entry_t;

  typedef enum logic {RUN, FLUSH} state_t;

  entry_t        rob_q [ROB_ENTRIES];
  logic [IW-1:0] head_q;
  logic [IW-1:0] tail_q;
  logic [CW-1:0] count_q;
  state_t        state_q;

  logic retire;
  logic do_commit;
  logic do_alloc;
  logic irq_cut;

  assign retire = rob_q[head_q].valid
               && !rob_q[head_q].busy
               && (state_q == RUN);

  assign do_commit = retire && !rob_q[head_q].exc;

  // Interrupts are only taken at a macro-op boundary, after it commits.
  assign irq_cut = do_commit
                && rob_q[head_q].mend
                && irq_pending;

  assign flush       = (retire && rob_q[head_q].exc) || irq_cut;
  assign flush_cause = irq_cut;

  assign commit_valid = do_commit;
  assign commit_areg  = rob_q[head_q].areg;
  assign commit_preg  = rob_q[head_q].preg;
  assign free_valid   = do_commit;
  assign free_preg    = rob_q[head_q].old_preg;

  assign alloc_ready = (state_q == RUN) && (count_q < C_MAX);
  assign alloc_idx   = tail_q;
  assign count       = count_q;

  assign do_alloc = alloc_valid && alloc_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        rob_q[i] <= '0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= RUN;
    end else if (flush) begin
      // Discarded entries keep their old_preg; rename recovery reclaims them.
      for (int i = 0; i < ROB_ENTRIES; i++) begin
        rob_q[i].valid <= 1'b0;
      end
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      state_q <= FLUSH;
    end else begin
      state_q <= RUN;
      if (cmpl_valid && rob_q[cmpl_idx].valid) begin
        rob_q[cmpl_idx].busy <= 1'b0;
        rob_q[cmpl_idx].exc  <= cmpl_exc;
      end
      if (do_commit) begin
        rob_q[head_q] <= '0;
        head_q        <= head_q + I_ONE;
      end
      if (do_alloc) begin
        rob_q[tail_q] <= '{
          valid:    1'b1,
          busy:     1'b1,
          exc:      1'b0,
          areg:     alloc_areg,
          preg:     alloc_preg,
          old_preg: alloc_old_preg,
          mbegin:   alloc_mbegin,
          mend:     alloc_mend
        };
        tail_q <= tail_q + I_ONE;
      end
      unique case ({do_alloc, do_commit})
        2'b10:   count_q <= count_q + C_ONE;
        2'b01:   count_q <= count_q - C_ONE;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: tb/tb_rob_commit.sv
// Scoreboard bench for rob_commit: queue-based reference model,
// directed scenarios then randomized traffic with a mid-run reset.
module tb_rob_commit;

  localparam int N = 16;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       alloc_valid = 1'b0;
  logic       alloc_ready;
  logic [4:0] alloc_areg = '0;
  logic [5:0] alloc_preg = '0;
  logic [5:0] alloc_old_preg = '0;
  logic       alloc_mbegin = 1'b0;
  logic       alloc_mend = 1'b0;
  logic [3:0] alloc_idx;
  logic       cmpl_valid = 1'b0;
  logic [3:0] cmpl_idx = '0;
  logic       cmpl_exc = 1'b0;
  logic       commit_valid;
  logic [4:0] commit_areg;
  logic [5:0] commit_preg;
  logic       free_valid;
  logic [5:0] free_preg;
  logic       irq_pending = 1'b0;
  logic       flush;
  logic       flush_cause;
  logic [4:0] count;

  rob_commit dut (
    .clk(clk), .rst_n(rst_n),
    .alloc_valid(alloc_valid), .alloc_ready(alloc_ready),
    .alloc_areg(alloc_areg), .alloc_preg(alloc_preg),
    .alloc_old_preg(alloc_old_preg),
    .alloc_mbegin(alloc_mbegin), .alloc_mend(alloc_mend),
    .alloc_idx(alloc_idx),
    .cmpl_valid(cmpl_valid), .cmpl_idx(cmpl_idx),
    .cmpl_exc(cmpl_exc),
    .commit_valid(commit_valid), .commit_areg(commit_areg),
    .commit_preg(commit_preg),
    .free_valid(free_valid), .free_preg(free_preg),
    .irq_pending(irq_pending),
    .flush(flush), .flush_cause(flush_cause),
    .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int areg; int preg; int old;
    bit mend; bit done; bit exc;
    int idx;
  } ment_t;

  typedef struct {
    bit ready; int idx; int cnt;
    bit cv; int areg; int preg;
    bit fv; int fpreg;
    bit fl; bit cause;
  } exp_t;

  ment_t mq[$];
  int    m_tail = 0;
  bit    m_flushing = 0;
  exp_t  exp_q[$];
  exp_t  mon_e;
  int    n_chk = 0;
  int    n_fail = 0;

  function automatic void chk(string name, int act, int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t",
               name, act, exp, $time);
    end
  endfunction

  // Expected outputs for the current cycle from model state + inputs.
  function automatic exp_t predict();
    exp_t e;
    bit   ret;
    e = '{default: 0};
    e.ready = !m_flushing && (mq.size() < N);
    e.idx = m_tail;
    e.cnt = mq.size();
    ret = 0;
    if (!m_flushing && mq.size() > 0) ret = mq[0].done;
    if (ret) begin
      e.cv    = !mq[0].exc;
      e.fv    = e.cv;
      e.areg  = mq[0].areg;
      e.preg  = mq[0].preg;
      e.fpreg = mq[0].old;
      e.fl    = mq[0].exc || (mq[0].mend && irq_pending);
      e.cause = !mq[0].exc && mq[0].mend && irq_pending;
    end
    return e;
  endfunction

  function automatic void update(exp_t e);
    ment_t t;
    if (e.fl) begin
      mq.delete();
      m_tail = 0;
      m_flushing = 1;
      return;
    end
    m_flushing = 0;
    if (cmpl_valid) begin
      foreach (mq[i]) begin
        if (mq[i].idx == int'(cmpl_idx)) begin
          t = mq[i];
          t.done = 1;
          t.exc = cmpl_exc;
          mq[i] = t;
        end
      end
    end
    if (e.cv) void'(mq.pop_front());
    if (alloc_valid && e.ready) begin
      t.areg = int'(alloc_areg);
      t.preg = int'(alloc_preg);
      t.old  = int'(alloc_old_preg);
      t.mend = alloc_mend;
      t.done = 0;
      t.exc  = 0;
      t.idx  = m_tail;
      mq.push_back(t);
      m_tail = (m_tail + 1) % N;
    end
  endfunction

  task automatic drive(bit av, int ar, int pr, int op, bit me,
                       bit cv, int ci, bit ce, bit irq);
    alloc_valid    = av;
    alloc_areg     = 5'(ar);
    alloc_preg     = 6'(pr);
    alloc_old_preg = 6'(op);
    alloc_mbegin   = me;
    alloc_mend     = me;
    cmpl_valid     = cv;
    cmpl_idx       = 4'(ci);
    cmpl_exc       = ce;
    irq_pending    = irq;
    exp_q.push_back(predict());
  endtask

  task automatic tick();
    exp_t e;
    e = predict();
    @(posedge clk);
    update(e);
    #1;
  endtask

  task automatic idle(bit irq);
    drive(0, 0, 0, 0, 0, 0, 0, 0, irq);
  endtask

  task automatic alloc1(int ar, int pr, int op, bit me);
    drive(1, ar, pr, op, me, 0, 0, 0, 0);
    tick();
  endtask

  task automatic cmpl1(int ci, bit ce, bit irq);
    drive(0, 0, 0, 0, 0, 1, ci, ce, irq);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_valid = 1'b0;
    cmpl_valid = 1'b0;
    irq_pending = 1'b0;
    #1;
    chk("rst_count", int'(count), 0);
    chk("rst_commit_valid", int'(commit_valid), 0);
    chk("rst_free_valid", int'(free_valid), 0);
    chk("rst_alloc_ready", int'(alloc_ready), 1);
    chk("rst_alloc_idx", int'(alloc_idx), 0);
    chk("rst_flush", int'(flush), 0);
    @(posedge clk);
    #1;
    chk("rst_hold_count", int'(count), 0);
    mq.delete();
    m_tail = 0;
    m_flushing = 0;
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      chk("free_during_reset", int'(free_valid), 0);
      chk("commit_during_reset", int'(commit_valid), 0);
    end else if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      chk("alloc_ready", int'(alloc_ready), int'(mon_e.ready));
      chk("alloc_idx", int'(alloc_idx), mon_e.idx);
      chk("count", int'(count), mon_e.cnt);
      chk("commit_valid", int'(commit_valid), int'(mon_e.cv));
      chk("free_valid", int'(free_valid), int'(mon_e.fv));
      chk("flush", int'(flush), int'(mon_e.fl));
      chk("flush_cause", int'(flush_cause), int'(mon_e.cause));
      if (mon_e.cv) begin
        chk("commit_areg", int'(commit_areg), mon_e.areg);
        chk("commit_preg", int'(commit_preg), mon_e.preg);
        chk("free_preg", int'(free_preg), mon_e.fpreg);
      end
    end
  end

  initial begin
    int h;
    int k;
    bit av;
    bit cv;
    int ci;

    #3;
    chk("init_alloc_ready", int'(alloc_ready), 1);
    chk("init_alloc_idx", int'(alloc_idx), 0);
    chk("init_count", int'(count), 0);
    chk("init_flush", int'(flush), 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // single alloc, complete, commit
    alloc1(3, 40, 7, 0);
    cmpl1(0, 0, 0);
    idle(0);
    #2;
    chk("d1_commit_valid", int'(commit_valid), 1);
    chk("d1_commit_areg", int'(commit_areg), 3);
    chk("d1_commit_preg", int'(commit_preg), 40);
    chk("d1_free_preg", int'(free_preg), 7);
    chk("d1_count_before", int'(count), 1);
    tick();
    idle(0);
    #2;
    chk("d1_count_after", int'(count), 0);
    tick();

    // fill to capacity, wrap tail
    do_reset();
    for (int i = 0; i < N; i++) alloc1(i, i + 10, i + 30, 0);
    idle(0);
    #2;
    chk("d2_full_count", int'(count), 16);
    chk("d2_full_ready", int'(alloc_ready), 0);
    chk("d2_wrap_idx", int'(alloc_idx), 0);
    tick();
    cmpl1(0, 0, 0);
    idle(0);
    #2;
    chk("d2_commit_valid", int'(commit_valid), 1);
    tick();
    idle(0);
    #2;
    chk("d2_ready_again", int'(alloc_ready), 1);
    chk("d2_idx_again", int'(alloc_idx), 0);
    chk("d2_count_15", int'(count), 15);
    tick();
    for (int i = 1; i < N; i++) cmpl1(i, 0, 0);
    for (int i = 0; i < 3; i++) begin idle(0); tick(); end

    // out-of-order completion
    h = m_tail;
    alloc1(10, 20, 21, 0);
    alloc1(11, 22, 23, 0);
    cmpl1((h + 1) % N, 0, 0);
    idle(0);
    #2;
    chk("d3_no_commit", int'(commit_valid), 0);
    tick();
    cmpl1(h, 0, 0);
    idle(0);
    #2;
    chk("d3_first_commit", int'(commit_valid), 1);
    chk("d3_first_areg", int'(commit_areg), 10);
    tick();
    idle(0);
    #2;
    chk("d3_second_commit", int'(commit_valid), 1);
    chk("d3_second_areg", int'(commit_areg), 11);
    tick();
    idle(0);
    tick();

    // exception flush
    h = m_tail;
    for (int i = 0; i < 4; i++) alloc1(i + 1, i + 2, i + 3, 0);
    cmpl1(h, 1, 0);
    idle(0);
    #2;
    chk("d4_flush", int'(flush), 1);
    chk("d4_cause", int'(flush_cause), 0);
    chk("d4_no_commit", int'(commit_valid), 0);
    chk("d4_no_free", int'(free_valid), 0);
    tick();
    idle(0);
    #2;
    chk("d4_count0", int'(count), 0);
    chk("d4_ready0", int'(alloc_ready), 0);
    tick();
    idle(0);
    #2;
    chk("d4_ready1", int'(alloc_ready), 1);
    chk("d4_idx0", int'(alloc_idx), 0);
    tick();

    // interrupt at macro-op end
    alloc1(20, 50, 51, 0);
    alloc1(21, 52, 53, 1);
    cmpl1(0, 0, 1);
    drive(0, 0, 0, 0, 0, 1, 1, 0, 1);
    #2;
    chk("d5_a_commit", int'(commit_valid), 1);
    chk("d5_a_areg", int'(commit_areg), 20);
    chk("d5_a_noflush", int'(flush), 0);
    tick();
    idle(1);
    #2;
    chk("d5_b_commit", int'(commit_valid), 1);
    chk("d5_b_areg", int'(commit_areg), 21);
    chk("d5_b_flush", int'(flush), 1);
    chk("d5_b_cause", int'(flush_cause), 1);
    tick();
    idle(0);
    tick();
    idle(0);
    tick();

    // reset with live entries, head retirable
    h = m_tail;
    for (int i = 0; i < 4; i++) alloc1(i + 5, i + 6, i + 7, 0);
    drive(1, 9, 9, 9, 0, 1, h, 0, 0);
    tick();
    do_reset();

    // randomized traffic
    for (int n = 0; n < 1500; n++) begin
      if (n == 700) do_reset();
      av = ($urandom_range(0, 9) < 6);
      cv = 0;
      ci = 0;
      if (mq.size() > 0 && $urandom_range(0, 9) < 5) begin
        k = $urandom_range(0, mq.size() - 1);
        cv = 1;
        ci = mq[k].idx;
      end else if ($urandom_range(0, 9) == 0) begin
        cv = 1;
        ci = $urandom_range(0, N - 1);
      end
      drive(av, $urandom_range(0, 31), $urandom_range(0, 63),
            $urandom_range(0, 63), $urandom_range(0, 1) == 1,
            cv, ci, $urandom_range(0, 19) == 0,
            $urandom_range(0, 9) == 0);
      tick();
    end

    idle(0);
    tick();
    @(negedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rob_commit.md
ROB_COMMIT -- requirements
Module: rob_commit

Interface
REQ-001 SHALL have parameter ROB_ENTRIES, default 16, reorder-buffer depth (power of two).
REQ-002 SHALL have parameter NUM_PREGS, default 64, physical register count.
REQ-003 SHALL have parameter NUM_AREGS, default 32, architectural register count.
REQ-004 SHALL have port clk  in  1  sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-006 SHALL have port alloc_valid  in  1  issue requests one new entry.
REQ-007 SHALL have port alloc_ready  out  1  an entry can be accepted this cycle.
REQ-008 SHALL have ports alloc_areg, alloc_preg, alloc_old_preg  in  clog2(NUM_AREGS)/clog2(NUM_PREGS)/clog2(NUM_PREGS)  destination mapping and previous physical register.
REQ-009 SHALL have ports alloc_mbegin, alloc_mend  in  1 each  macro-op begin/end flags.
REQ-010 SHALL have port alloc_idx  out  clog2(ROB_ENTRIES)  index given to the allocated entry (current tail).
REQ-011 SHALL have ports cmpl_valid  in  1, cmpl_idx  in  clog2(ROB_ENTRIES), cmpl_exc  in  1  execution completion, entry index, exception flag.
REQ-012 SHALL have ports commit_valid  out  1, commit_areg  out  clog2(NUM_AREGS), commit_preg  out  clog2(NUM_PREGS)  commit-RAT write.
REQ-013 SHALL have ports free_valid  out  1, free_preg  out  clog2(NUM_PREGS)  release of previous physical register.
REQ-014 SHALL have port irq_pending  in  1  external interrupt request.
REQ-015 SHALL have ports flush  out  1, flush_cause  out  1 (0 exception, 1 interrupt)  pipeline flush.
REQ-016 SHALL have port count  out  clog2(ROB_ENTRIES)+1  occupied entries.

Function
REQ-017 SHALL store per entry: valid, busy, exception, areg, preg, old_preg, mbegin, mend; circular buffer with head (oldest) and tail pointers, wrapping ROB_ENTRIES-1 -> 0.
REQ-018 SHALL drive alloc_ready = (state==RUN) && (count < ROB_ENTRIES), independent of same-cycle commit.
REQ-019 SHALL, on alloc_valid && alloc_ready, write the tail entry with valid=1, busy=1, exception=0 and advance tail by 1.
REQ-020 SHALL, on cmpl_valid to a valid entry, clear busy and set exception=cmpl_exc; completion to an invalid entry SHALL be ignored.
REQ-021 SHALL drive commit outputs combinationally from head entry; head is retirable when valid && !busy && state==RUN.
REQ-022 SHALL, for retirable head with exception=0: assert commit_valid and free_valid (commit_preg=preg, free_preg=old_preg), clear entry, advance head at edge.
REQ-023 SHALL, for retirable head with exception=1: commit_valid=0, free_valid=0, flush=1, flush_cause=0.
REQ-024 SHALL, for retirable non-exception head with mend=1 while irq_pending=1: commit normally plus flush=1, flush_cause=1.
REQ-025 SHALL, at an edge with flush=1: clear all valid bits, set head=tail=0, count=0, ignore same-cycle alloc and cmpl, enter FLUSH.
REQ-026 SHALL have states RUN and FLUSH; FLUSH lasts exactly one cycle (alloc_ready=0, no commit), then RUN.
REQ-027 SHALL not free old_preg of entries discarded by flush (rename recovery owns them).
REQ-028 SHALL update count +1 on alloc, -1 on commit, unchanged on both, commit at most one entry per cycle.
REQ-029 SHALL keep a completion landing on head at edge N retiring during cycle N+1 (one-cycle completion-to-commit latency).

Reset
REQ-030 SHALL, while rst_n=0, asynchronously set all valid/busy/exception to 0, head=tail=0, count=0, state=RUN.
REQ-031 SHALL hold outputs during reset: alloc_ready=1, alloc_idx=0, commit_valid=0, free_valid=0, flush=0, flush_cause=0, count=0.
REQ-032 SHALL, on reset asserted mid-operation, discard all entries without any commit or free.

Verification
REQ-033 SHALL: alloc areg=3/preg=40/old=7 at idx 0, cmpl idx 0 next cycle -> following cycle commit_valid=1, commit_areg=3, commit_preg=40, free_preg=7, count 1->0.
REQ-034 SHALL: 16 allocs without completion -> count=16, alloc_ready=0, tail wraps to 0; complete idx 0, commit -> alloc_ready=1 with alloc_idx=0.
REQ-035 SHALL: complete idx 1 before idx 0 -> no commit until idx 0 completes, then idx 0 and idx 1 commit on consecutive cycles.
REQ-036 SHALL: 4 entries, head completes with cmpl_exc=1 -> flush=1, flush_cause=0, commit_valid=0; next cycle count=0, alloc_ready=0; cycle after alloc_ready=1, alloc_idx=0.
REQ-037 SHALL: irq_pending=1, head with mend=0 commits without flush; next head mend=1 commits with flush=1, flush_cause=1.
REQ-038 SHALL: rst_n low for one cycle with 5 entries valid -> count=0, commit_valid=0 immediately, no free_valid pulse.
